// File: rtl/stage_mem_sequencer_if.sv
// Memory request bus between the stage sequencer (master) and the memory (slave).
interface stage_mem_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_valid;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/stage_mem_sequencer.sv
// Issues one fetch or load/store per pipeline stage and stalls the stage counter until it completes.
// Optional MEM_TIMEOUT_EN: watchdog abandons a request after TIMEOUT_CYCLES and sets sticky mem_err_o.
module stage_mem_sequencer #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned FETCH_STAGE    = 0,
  parameter int unsigned MEM_STAGE      = 3
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            stage_i,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [XLEN-1:0]       data_addr_i,
  input  logic [XLEN-1:0]       store_data_i,
  stage_mem_sequencer_if.master mem,
  output logic                  blocked_o,
  output logic [XLEN-1:0]       instr_q_o,
  output logic [XLEN-1:0]       load_q_o,
  output logic                  mem_err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] load_q, load_d;
  logic            fetch_q, fetch_d;
  logic            ld_q, ld_d;
  logic            err_q, err_d;

  logic fetch_c;
  logic need_c;

  assign fetch_c = (stage_i == 3'(FETCH_STAGE));
  assign need_c  = fetch_c | ((stage_i == 3'(MEM_STAGE)) & (is_load_i | is_store_i));

`ifdef MEM_TIMEOUT_EN
  logic [3:0] wait_q, wait_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      load_q  <= '0;
      fetch_q <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      load_q  <= load_d;
      fetch_q <= fetch_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    load_d  = load_q;
    fetch_d = fetch_q;
    ld_d    = ld_q;
    err_d   = err_q;
`ifdef MEM_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (need_c) begin
          state_d = REQ;
          valid_d = 1'b1;
          addr_d  = fetch_c ? pc_i : data_addr_i;
          we_d    = !fetch_c & is_store_i;
          wdata_d = store_data_i;
          fetch_d = fetch_c;
          // load+store together is a store, so load_q is left alone
          ld_d    = !fetch_c & is_load_i & !is_store_i;
`ifdef MEM_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          state_d = DONE;
          valid_d = 1'b0;
          we_d    = 1'b0;
          if (fetch_q)   instr_d = mem.mem_rdata;
          else if (ld_q) load_d  = mem.mem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_q == 4'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          valid_d = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          wait_d  = wait_q + 4'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational stall so the counter holds in the very cycle the access is detected
  assign blocked_o = !rst & (((state_q == IDLE) & need_c) | (state_q == REQ));

  assign mem.mem_valid = valid_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign instr_q_o     = instr_q;
  assign load_q_o      = load_q;
  assign mem_err_o     = err_q;

endmodule

// File: tb/tb_stage_mem_sequencer.sv
// Directed bench for stage_mem_sequencer; define MEM_TIMEOUT_EN to also exercise the watchdog.
module tb_stage_mem_sequencer;

  logic        clk;
  logic        rst;
  logic [2:0]  stage;
  logic        is_load;
  logic        is_store;
  logic [31:0] pc;
  logic [31:0] data_addr;
  logic [31:0] store_data;
  logic        blocked;
  logic [31:0] instr_q;
  logic [31:0] load_q;
  logic        mem_err;

  int n_cmp = 0;
  int n_err = 0;

  stage_mem_sequencer_if #(.XLEN(32)) mem_bus ();

  stage_mem_sequencer #(.XLEN(32), .FETCH_STAGE(0), .MEM_STAGE(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .stage_i      (stage),
    .is_load_i    (is_load),
    .is_store_i   (is_store),
    .pc_i         (pc),
    .data_addr_i  (data_addr),
    .store_data_i (store_data),
    .mem          (mem_bus.master),
    .blocked_o    (blocked),
    .instr_q_o    (instr_q),
    .load_q_o     (load_q),
    .mem_err_o    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one access from its IDLE detect cycle; returns in DONE with the number of stalled cycles
  task automatic do_access(input int delay, input logic [31:0] exp_addr, input logic exp_we,
                           input logic [31:0] exp_wdata, output int blk);
    int req;
    bit done;
    blk  = 0;
    req  = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!blocked) begin
        done = 1;
      end else begin
        blk++;
        if (mem_bus.mem_valid) begin
          check("req_addr", mem_bus.mem_addr, exp_addr);
          check("req_we", 32'(mem_bus.mem_we), 32'(exp_we));
          check("req_wdata", mem_bus.mem_wdata, exp_wdata);
          mem_bus.mem_ready = (req == delay);
          req++;
        end else begin
          mem_bus.mem_ready = 1'b0;
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Leaves DONE toward a non-access stage and confirms the block idles
  task automatic release_stage();
    stage             = 3'd4;
    is_load           = 1'b0;
    is_store          = 1'b0;
    mem_bus.mem_ready = 1'b0;
    @(posedge clk);
    #2;
    check("post_blocked", 32'(blocked), 32'd0);
    check("post_valid", 32'(mem_bus.mem_valid), 32'd0);
  endtask

  int blk;

  initial begin
    rst               = 1'b1;
    stage             = 3'd1;
    is_load           = 1'b0;
    is_store          = 1'b0;
    pc                = '0;
    data_addr         = '0;
    store_data        = '0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;
    #3;
    check("rst_blocked", 32'(blocked), 32'd0);
    check("rst_valid", 32'(mem_bus.mem_valid), 32'd0);
    check("rst_we", 32'(mem_bus.mem_we), 32'd0);
    check("rst_addr", mem_bus.mem_addr, 32'd0);
    check("rst_instr", instr_q, 32'd0);
    check("rst_load", load_q, 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fetch with ready already high: 2 stalled cycles then DONE
    stage             = 3'd0;
    pc                = 32'h100;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'h0050_0093;
    #1;
    check("f0_idle_blocked", 32'(blocked), 32'd1);
    check("f0_idle_valid", 32'(mem_bus.mem_valid), 32'd0);
    @(posedge clk);
    #2;
    check("f0_req_blocked", 32'(blocked), 32'd1);
    check("f0_req_valid", 32'(mem_bus.mem_valid), 32'd1);
    check("f0_req_addr", mem_bus.mem_addr, 32'h100);
    check("f0_req_instr", instr_q, 32'd0);
    @(posedge clk);
    #2;
    check("f0_done_blocked", 32'(blocked), 32'd0);
    check("f0_done_valid", 32'(mem_bus.mem_valid), 32'd0);
    check("f0_instr", instr_q, 32'h0050_0093);
    release_stage();

    // Fetch with ready three cycles late: 4 REQ cycles, 5 stalled
    stage             = 3'd0;
    pc                = 32'h104;
    mem_bus.mem_rdata = 32'h00A0_0113;
    do_access(3, 32'h104, 1'b0, store_data, blk);
    check("f3_blk_cycles", 32'(blk), 32'd5);
    check("f3_instr", instr_q, 32'h00A0_0113);
    check("f3_done_valid", 32'(mem_bus.mem_valid), 32'd0);
    release_stage();

    // Store: write enable asserted, load_q untouched
    stage             = 3'd3;
    is_store          = 1'b1;
    data_addr         = 32'h2000;
    store_data        = 32'hDEAD_BEEF;
    mem_bus.mem_rdata = 32'h7777_7777;
    do_access(1, 32'h2000, 1'b1, 32'hDEAD_BEEF, blk);
    check("st_blk_cycles", 32'(blk), 32'd3);
    check("st_we_after", 32'(mem_bus.mem_we), 32'd0);
    check("st_load", load_q, 32'd0);
    check("st_instr", instr_q, 32'h00A0_0113);
    release_stage();

    // Load: captured into load_q, instruction register untouched
    stage             = 3'd3;
    is_load           = 1'b1;
    data_addr         = 32'h3000;
    mem_bus.mem_rdata = 32'hCAFE_F00D;
    do_access(0, 32'h3000, 1'b0, 32'hDEAD_BEEF, blk);
    check("ld_blk_cycles", 32'(blk), 32'd2);
    check("ld_load", load_q, 32'hCAFE_F00D);
    check("ld_instr", instr_q, 32'h00A0_0113);
    release_stage();

    // Load and store together behave as a store
    stage             = 3'd3;
    is_load           = 1'b1;
    is_store          = 1'b1;
    data_addr         = 32'h3004;
    store_data        = 32'h1234_5678;
    mem_bus.mem_rdata = 32'h5555_5555;
    do_access(0, 32'h3004, 1'b1, 32'h1234_5678, blk);
    check("ls_blk_cycles", 32'(blk), 32'd2);
    check("ls_load", load_q, 32'hCAFE_F00D);
    release_stage();

    // Non-access stages idle even with ready high
    mem_bus.mem_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      logic [2:0] st_tab [4];
      st_tab = '{3'd1, 3'd2, 3'd4, 3'd3};
      stage    = st_tab[s];
      is_load  = 1'b0;
      is_store = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #2;
        check($sformatf("na_s%0d_blocked", st_tab[s]), 32'(blocked), 32'd0);
        check($sformatf("na_s%0d_valid", st_tab[s]), 32'(mem_bus.mem_valid), 32'd0);
      end
    end
    mem_bus.mem_ready = 1'b0;

    // Asynchronous reset while a fetch is outstanding
    stage = 3'd0;
    pc    = 32'h200;
    @(posedge clk);
    #2;
    check("rq_valid", 32'(mem_bus.mem_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rq_rst_valid", 32'(mem_bus.mem_valid), 32'd0);
    check("rq_rst_blocked", 32'(blocked), 32'd0);
    check("rq_rst_addr", mem_bus.mem_addr, 32'd0);
    check("rq_rst_instr", instr_q, 32'd0);
    check("rq_rst_load", load_q, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_bus.mem_rdata = 32'h0000_0013;
    do_access(0, 32'h200, 1'b0, 32'h1234_5678, blk);
    check("rq_blk_cycles", 32'(blk), 32'd2);
    check("rq_instr", instr_q, 32'h0000_0013);
    release_stage();

`ifdef MEM_TIMEOUT_EN
    // Watchdog: 15 unanswered REQ cycles, then DONE with sticky error
    begin
      int req_cycles;
      req_cycles        = 0;
      stage             = 3'd0;
      pc                = 32'h300;
      mem_bus.mem_ready = 1'b0;
      @(posedge clk);
      #2;
      for (int c = 0; c < 40 && mem_bus.mem_valid; c++) begin
        req_cycles++;
        @(posedge clk);
        #2;
      end
      check("to_req_cycles", 32'(req_cycles), 32'd15);
      check("to_err", 32'(mem_err), 32'd1);
      check("to_valid", 32'(mem_bus.mem_valid), 32'd0);
      check("to_done_blocked", 32'(blocked), 32'd0);
      check("to_instr", instr_q, 32'h0000_0013);
      release_stage();
      check("to_err_sticky", 32'(mem_err), 32'd1);
    end
`else
    check("err_tied_low", 32'(mem_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stage_mem_sequencer.md
Name: stage_mem_sequencer

Overview:
- Sits directly upstream of the CPU stage counter and drives that counter's `blocked` input.
- Watches the current stage number. In the fetch stage, and in the memory stage for loads/stores, it issues one memory transaction on a valid/ready bus.
- Holds the stage counter stalled until the transaction completes, then releases it for exactly one cycle.
- Latches returned read data for the decode and writeback logic.

Parameters:
- XLEN, 32, width of address and data buses.
- FETCH_STAGE, 0, stage number that always performs an instruction read.
- MEM_STAGE, 3, stage number that performs a data access when is_load or is_store.
- TIMEOUT_CYCLES, 15, watchdog limit in cycles waiting for mem_ready (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stage  in  3  current stage number from the stage counter.
- is_load  in  1  decoded instruction is a load; sampled in MEM_STAGE.
- is_store  in  1  decoded instruction is a store; sampled in MEM_STAGE.
- pc  in  XLEN  fetch address.
- data_addr  in  XLEN  load/store address from the ALU.
- store_data  in  XLEN  store write data.
- mem_ready  in  1  memory accepts and completes the current request.
- mem_rdata  in  XLEN  read data; valid when mem_ready=1.
- blocked  out  1  stall to the stage counter.
- mem_valid  out  1  request valid.
- mem_we  out  1  write enable.
- mem_addr  out  XLEN  request address.
- mem_wdata  out  XLEN  request write data.
- instr_q  out  XLEN  last fetched instruction.
- load_q  out  XLEN  last loaded data word.
- mem_err  out  1  watchdog fired (sticky; tied 0 without the optional feature).

Behaviour:
- States: IDLE, REQ, DONE (encoded in 2 bits).
- need = (stage==FETCH_STAGE) | (stage==MEM_STAGE & (is_load|is_store)).
- blocked is combinational: (IDLE & need) | REQ. It is 0 in DONE and 0 while rst=1.
- IDLE & need, on the clock edge:
  - go to REQ.
  - Register mem_addr = fetch ? pc : data_addr.
  - Register mem_we = (MEM_STAGE & is_store).
  - Register mem_wdata = store_data.
  - Register mem_valid = 1.
- REQ:
  - mem_valid, mem_we, mem_addr and mem_wdata are held stable until mem_ready is sampled high.
  - On mem_ready=1: mem_valid←0 and mem_we←0 at that edge; go to DONE.
  - If the access was a fetch, instr_q←mem_rdata.
  - If the access was a load, load_q←mem_rdata.
  - A store updates neither register.
- DONE: blocked=0 for exactly one cycle so the stage counter advances. Next state is IDLE unconditionally, so the same stage never issues twice.
- IDLE & !need: blocked=0, no request issued.
- Latency:
  - Minimum stall is 2 cycles per access: the IDLE detect cycle plus one REQ cycle with ready already high.
  - The counter advances on the edge that ends DONE.
- mem_ready while mem_valid=0 is ignored.
- is_load and is_store both set: treated as a store. mem_we=1, load_q unchanged.
- is_load/is_store are sampled only on the IDLE→REQ edge. Later changes do not affect an issued request.
- Stage mismatch: when stage is neither FETCH_STAGE nor MEM_STAGE, the block idles.
- Reset, including mid-transaction:
  - state=IDLE, mem_valid=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, instr_q=0, load_q=0, mem_err=0.
  - An outstanding request is abandoned. The memory side must tolerate valid dropping.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter clears on entry to REQ and increments each REQ cycle with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES without ready: mem_err←1 (sticky until rst), mem_valid←0, go to DONE, instr_q and load_q unchanged. The pipeline continues.
- Not defined: no counter, mem_err is constant 0, REQ waits indefinitely.

Test Plan:
- Fetch with immediate ready:
  - Stimulus: rst pulse; stage=0, pc=0x100, mem_ready=1, mem_rdata=0x00500093.
  - Response: blocked=1 for 2 cycles; mem_valid=1 with mem_addr=0x100 for one cycle; then DONE with blocked=0 for 1 cycle; instr_q=0x00500093.
- Fetch with 3-cycle ready delay:
  - Response: mem_valid and mem_addr held for 4 REQ cycles; blocked=1 for 5 cycles total; instr_q updated only on the ready cycle.
- Store:
  - Stimulus: stage=3, is_store=1, data_addr=0x2000, store_data=0xDEADBEEF.
  - Response: mem_we=1, mem_addr=0x2000, mem_wdata=0xDEADBEEF; load_q unchanged; mem_we=0 after completion.
- Non-access stage:
  - Stimulus: stage=3 with is_load=is_store=0; stages 1, 2, 4.
  - Response: blocked=0 and mem_valid=0 throughout.
- Reset during REQ:
  - Stimulus: assert rst asynchronously while mem_valid=1 and mem_ready=0.
  - Response: mem_valid=0 and blocked=0 immediately; state is IDLE after release; a fetch reissues normally.
- MEM_TIMEOUT_EN defined:
  - Stimulus: stage=0, mem_ready held 0.
  - Response: after 15 REQ cycles mem_err=1 and mem_valid=0; DONE releases blocked for 1 cycle; mem_err stays 1 until rst.
